dmem_avalon_slave: RTL and testbench

- Word-addressed on-chip data memory that acts as the responder on the core's data-memory master port (addr, writedata, read_en, write_en, byteenable, waitrequest, readdata).
- Every access is stretched with a parameterised number of wait states using waitrequest, so the pipeline stall path is exercised.
- Sits between the core's MEM stage and the system interconnect, or is directly attached to the core in single-core builds.

---
 rtl/dmem_avalon_slave.sv | 150 +++++++++++++++
 tb/tb_dmem_avalon_slave.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_avalon_slave.sv
// dmem_avalon_slave: word-addressed data RAM responder; DMEM_BYTEEN_EN enables per-byte write masks.
// Latency: waitrequest drops LATENCY+1 cycles after a request for one ACK cycle; the master is stalled until then.
module dmem_avalon_slave #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    input  logic              read_en,
    input  logic              write_en,
    output logic              waitrequest,
    output logic [31:0]       readdata,
    output logic              access_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] LAT_LD = 4'(LATENCY);
    localparam logic [ADDR_W-2:0] DEPTH_LIM = (ADDR_W-1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_load;
    logic                r_live;
    logic [3:0]          r_cnt;
    logic [ADDR_W-3:0]   r_idx;
    logic [31:0]         r_wdat;
    logic                r_rd;
    logic                r_wr;
    logic [31:0]         r_rdata;
    logic                r_err;
    logic [31:0]         r_mem [DEPTH];

    logic                w_in_idle;
    logic                w_enter_ack;
    logic [ADDR_W-3:0]   w_idx;
    logic [AW-1:0]       w_widx;
    logic [31:0]         w_wdat;
    logic                w_rd;
    logic                w_wr;
    logic                w_oor;
    logic                w_mem_we;

`ifdef DMEM_BYTEEN_EN
    logic [3:0]          r_be;
    logic [3:0]          w_be;
    logic                w_unused_bits;
    assign w_unused_bits = ^addr[1:0];
`else
    logic                w_unused_bits;
    assign w_unused_bits = ^{addr[1:0], byteenable};
`endif

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            S_IDLE: begin
                // r_live blocks acceptance on the first edge after reset release
                if (r_live && (read_en || write_en)) begin
                    w_load = 1'b1;
                    w_next = (LATENCY == 0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!read_en && !write_en) begin
                    w_next = S_IDLE;
                end else if (r_cnt == 4'd1) begin
                    w_next = S_ACK;
                end
            end
            S_ACK:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // With zero wait states the ACK edge is the capture edge, so bypass the capture registers.
    assign w_in_idle   = (r_state == S_IDLE);
    assign w_enter_ack = (r_state != S_ACK) && (w_next == S_ACK);
    assign w_idx       = w_in_idle ? addr[ADDR_W-1:2] : r_idx;
    assign w_wdat      = w_in_idle ? writedata        : r_wdat;
    assign w_rd        = w_in_idle ? read_en          : r_rd;
    assign w_wr        = w_in_idle ? write_en         : r_wr;
    assign w_widx      = w_idx[AW-1:0];
    assign w_oor       = ({1'b0, w_idx} >= DEPTH_LIM);
    assign w_mem_we    = w_enter_ack && w_wr && !w_oor && r_live;
`ifdef DMEM_BYTEEN_EN
    assign w_be        = w_in_idle ? byteenable : r_be;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_live  <= 1'b0;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_wdat  <= 32'd0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
`ifdef DMEM_BYTEEN_EN
            r_be    <= 4'd0;
`endif
        end else begin
            r_state <= w_next;
            r_live  <= 1'b1;
            r_err   <= w_enter_ack && w_oor;
            if (w_load) begin
                r_cnt  <= LAT_LD;
                r_idx  <= addr[ADDR_W-1:2];
                r_wdat <= writedata;
                r_rd   <= read_en;
                r_wr   <= write_en;
`ifdef DMEM_BYTEEN_EN
                r_be   <= byteenable;
`endif
            end else if (r_state == S_WAIT && w_next == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_ack && w_rd) begin
                r_rdata <= w_oor ? 32'd0 : r_mem[w_widx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
`ifdef DMEM_BYTEEN_EN
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_widx][8*b +: 8] <= w_wdat[8*b +: 8];
                end
            end
`else
            r_mem[w_widx] <= w_wdat;
`endif
        end
    end

    assign waitrequest = (r_state != S_ACK);
    assign readdata    = r_rdata;
    assign access_err  = r_err;

endmodule

// File: tb/tb_dmem_avalon_slave.sv
// Directed bench for dmem_avalon_slave with LATENCY 0, 1 and 3 instances on a shared address/data bus.
module tb_dmem_avalon_slave;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] writedata = 32'd0;
    logic [3:0]  byteenable = 4'hF;
    logic        rd_en [3];
    logic        wr_en [3];
    logic        wreq  [3];
    logic [31:0] rdat  [3];
    logic        err   [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_avalon_slave #(.DEPTH(1024), .LATENCY(0), .ADDR_W(32)) u_lat0 (
        .clk(clk), .reset(reset), .addr(addr), .writedata(writedata), .byteenable(byteenable),
        .read_en(rd_en[0]), .write_en(wr_en[0]), .waitrequest(wreq[0]), .readdata(rdat[0]),
        .access_err(err[0]));
    dmem_avalon_slave #(.DEPTH(1024), .LATENCY(1), .ADDR_W(32)) u_lat1 (
        .clk(clk), .reset(reset), .addr(addr), .writedata(writedata), .byteenable(byteenable),
        .read_en(rd_en[1]), .write_en(wr_en[1]), .waitrequest(wreq[1]), .readdata(rdat[1]),
        .access_err(err[1]));
    dmem_avalon_slave #(.DEPTH(1024), .LATENCY(3), .ADDR_W(32)) u_lat3 (
        .clk(clk), .reset(reset), .addr(addr), .writedata(writedata), .byteenable(byteenable),
        .read_en(rd_en[2]), .write_en(wr_en[2]), .waitrequest(wreq[2]), .readdata(rdat[2]),
        .access_err(err[2]));

    // Drives one access on instance s and reports the first cycle with waitrequest low.
    task automatic access(input int s, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be, output int lowc,
                          output logic [31:0] rv, output logic ev, output logic after_w,
                          output logic after_e);
        @(negedge clk);
        addr = a; writedata = d; byteenable = be; rd_en[s] = rd; wr_en[s] = wr;
        lowc = -1; rv = 32'hxxxxxxxx; ev = 1'bx;
        #1;
        for (int c = 0; c < 40; c++) begin
            if (wreq[s] === 1'b0) begin
                lowc = c; rv = rdat[s]; ev = err[s];
                break;
            end
            @(negedge clk); #1;
        end
        @(negedge clk);
        rd_en[s] = 1'b0; wr_en[s] = 1'b0;
        #1;
        after_w = wreq[s]; after_e = err[s];
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            total++; if (wreq[s] !== 1'b1) begin bad++; $display("FAIL rst_wreq[%0d] got=%b exp=1", s, wreq[s]); end
            total++; if (rdat[s] !== 32'd0) begin bad++; $display("FAIL rst_rdata[%0d] got=%h exp=0", s, rdat[s]); end
            total++; if (err[s] !== 1'b0) begin bad++; $display("FAIL rst_err[%0d] got=%b exp=0", s, err[s]); end
        end
    endtask

    task automatic test_write_read();
        int lc; logic [31:0] rv; logic ev, aw, ae;
        access(1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lc, rv, ev, aw, ae);
        total++; if (lc !== 2) begin bad++; $display("FAIL wr_lat got=%0d exp=2", lc); end
        total++; if (ev !== 1'b0) begin bad++; $display("FAIL wr_err got=%b exp=0", ev); end
        total++; if (aw !== 1'b1) begin bad++; $display("FAIL wr_one_ack got=%b exp=1", aw); end
        access(1, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, lc, rv, ev, aw, ae);
        total++; if (lc !== 2) begin bad++; $display("FAIL rd_lat got=%0d exp=2", lc); end
        total++; if (rv !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%h exp=deadbeef", rv); end
    endtask

    task automatic test_latency();
        int lc; logic [31:0] rv; logic ev, aw, ae;
        access(0, 1'b0, 1'b1, 32'h40, 32'h12345678, 4'hF, lc, rv, ev, aw, ae);
        total++; if (lc !== 1) begin bad++; $display("FAIL lat0_wr got=%0d exp=1", lc); end
        access(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF, lc, rv, ev, aw, ae);
        total++; if (lc !== 1) begin bad++; $display("FAIL lat0_rd got=%0d exp=1", lc); end
        total++; if (rv !== 32'h12345678) begin bad++; $display("FAIL lat0_data got=%h exp=12345678", rv); end
        total++; if (aw !== 1'b1) begin bad++; $display("FAIL lat0_one_ack got=%b exp=1", aw); end
        access(2, 1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, lc, rv, ev, aw, ae);
        total++; if (lc !== 4) begin bad++; $display("FAIL lat3_wr got=%0d exp=4", lc); end
        access(2, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF, lc, rv, ev, aw, ae);
        total++; if (lc !== 4) begin bad++; $display("FAIL lat3_rd got=%0d exp=4", lc); end
        total++; if (rv !== 32'hCAFEF00D) begin bad++; $display("FAIL lat3_data got=%h exp=cafef00d", rv); end
        total++; if (aw !== 1'b1) begin bad++; $display("FAIL lat3_one_ack got=%b exp=1", aw); end
    endtask

    task automatic test_byteen();
        int lc; logic [31:0] rv; logic ev, aw, ae;
        logic [31:0] exp_mask, exp_zero;
`ifdef DMEM_BYTEEN_EN
        exp_mask = 32'h11BB33DD; exp_zero = 32'h11BB33DD;
`else
        exp_mask = 32'hAABBCCDD; exp_zero = 32'hFFFFFFFF;
`endif
        access(1, 1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, lc, rv, ev, aw, ae);
        access(1, 1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, lc, rv, ev, aw, ae);
        access(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, lc, rv, ev, aw, ae);
        total++; if (rv !== exp_mask) begin bad++; $display("FAIL be_0101 got=%h exp=%h", rv, exp_mask); end
        access(1, 1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, lc, rv, ev, aw, ae);
        total++; if (lc !== 2) begin bad++; $display("FAIL be_0000_lat got=%0d exp=2", lc); end
        access(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, lc, rv, ev, aw, ae);
        total++; if (rv !== exp_zero) begin bad++; $display("FAIL be_0000 got=%h exp=%h", rv, exp_zero); end
    endtask

    task automatic test_out_of_range();
        int lc; logic [31:0] rv; logic ev, aw, ae;
        access(1, 1'b0, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, lc, rv, ev, aw, ae);
        access(1, 1'b1, 1'b0, 32'h1000, 32'h0, 4'hF, lc, rv, ev, aw, ae);
        total++; if (rv !== 32'd0) begin bad++; $display("FAIL oor_rdata got=%h exp=0", rv); end
        total++; if (ev !== 1'b1) begin bad++; $display("FAIL oor_err got=%b exp=1", ev); end
        total++; if (ae !== 1'b0) begin bad++; $display("FAIL oor_err_pulse got=%b exp=0", ae); end
        access(1, 1'b0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, lc, rv, ev, aw, ae);
        total++; if (ev !== 1'b1) begin bad++; $display("FAIL oor_wr_err got=%b exp=1", ev); end
        access(1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, lc, rv, ev, aw, ae);
        total++; if (rv !== 32'h0BADF00D) begin bad++; $display("FAIL oor_word0 got=%h exp=0badf00d", rv); end
        total++; if (ev !== 1'b0) begin bad++; $display("FAIL inrange_err got=%b exp=0", ev); end
        access(1, 1'b1, 1'b0, 32'h3, 32'h0, 4'hF, lc, rv, ev, aw, ae);
        total++; if (rv !== 32'h0BADF00D || ev !== 1'b0) begin bad++; $display("FAIL misalign got=%h/%b exp=0badf00d/0", rv, ev); end
    endtask

    task automatic test_collision();
        int lc; logic [31:0] rv; logic ev, aw, ae;
        access(1, 1'b0, 1'b1, 32'h8, 32'h5, 4'hF, lc, rv, ev, aw, ae);
        access(1, 1'b1, 1'b1, 32'h8, 32'h9, 4'hF, lc, rv, ev, aw, ae);
        total++; if (rv !== 32'h5) begin bad++; $display("FAIL coll_old got=%h exp=00000005", rv); end
        access(1, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF, lc, rv, ev, aw, ae);
        total++; if (rv !== 32'h9) begin bad++; $display("FAIL coll_new got=%h exp=00000009", rv); end
    endtask

    task automatic test_abort();
        int lows;
        @(negedge clk);
        addr = 32'h44; rd_en[2] = 1'b1;
        lows = 0;
        if (wreq[2] === 1'b0) lows++;
        @(negedge clk);
        if (wreq[2] === 1'b0) lows++;
        @(negedge clk);
        rd_en[2] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1; if (wreq[2] === 1'b0) lows++;
            @(negedge clk);
        end
        total++; if (lows !== 0) begin bad++; $display("FAIL abort_ack got=%0d exp=0", lows); end
        total++; if (rdat[2] !== 32'hCAFEF00D) begin bad++; $display("FAIL abort_rdata got=%h exp=cafef00d", rdat[2]); end
    endtask

    task automatic test_reset_mid();
        int lc; logic [31:0] rv; logic ev, aw, ae;
        @(negedge clk);
        addr = 32'h40; writedata = 32'h55555555; byteenable = 4'hF; wr_en[2] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if (wreq[2] !== 1'b1) begin bad++; $display("FAIL rstmid_wreq got=%b exp=1", wreq[2]); end
        total++; if (rdat[2] !== 32'd0) begin bad++; $display("FAIL rstmid_rdata got=%h exp=0", rdat[2]); end
        wr_en[2] = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        access(2, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF, lc, rv, ev, aw, ae);
        total++; if (lc !== 4) begin bad++; $display("FAIL rstmid_lat got=%0d exp=4", lc); end
        total++; if (rv !== 32'hCAFEF00D) begin bad++; $display("FAIL rstmid_word got=%h exp=cafef00d", rv); end
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin
            rd_en[s] = 1'b0; wr_en[s] = 1'b0;
        end
        repeat (3) @(negedge clk);
        #1;
        test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        test_write_read();
        test_latency();
        test_byteen();
        test_out_of_range();
        test_collision();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
